res_ram_arbiter: RTL and testbench
==================================

# res_ram_arbiter

Shares the single-port result RAM (16384 × 8, synchronous read) between two requesters. Requester A is the distance-transform engine; requester B is the host/test readback and initialisation port. The block accepts at most one access per cycle and drives registered RAM commands. It returns read data to the owning requester with fixed latency, using round-robin fairness, an optional ownership lock for read-modify-write sequences, and a starvation override.

## Interface
- ADDR_W, 14, RAM address width (128 × 128 image)
- DATA_W, 8, RAM data width
- STARVE_MAX, 4, consecutive blocked cycles before a lock is overridden (1..15)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- a_req / b_req  in  1  access request, held until granted
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  access address
- a_wdata / b_wdata  in  DATA_W  write data
- a_lock / b_lock  in  1  keep ownership after this grant while asserted
- a_gnt / b_gnt  out  1  combinational grant; request consumed this cycle
- a_rvalid / b_rvalid  out  1  read data valid for that requester
- a_rdata / b_rdata  out  DATA_W  read data (res_di routed through; the non-owner's copy is 0)
- res_rd  out  1  RAM read strobe
- res_wr  out  1  RAM write strobe
- res_addr  out  ADDR_W  RAM address
- res_do  out  DATA_W  RAM write data
- res_di  in  DATA_W  RAM read data, valid the cycle after res_rd

## Operation
- States:
  - IDLE: no owner.
  - OWN_A: A holds a lock.
  - OWN_B: B holds a lock.
- Priority pointer `last`: reset value B, so A wins the first tie.
- Grant rules:
  - IDLE, one requester active: that requester is granted.
  - IDLE, both active: the requester other than `last` is granted.
  - OWN_x: only x may be granted. The other requester is held off, and its blocked counter increments each cycle it requests without a grant.
- At most one gnt is high per cycle; a_gnt & b_gnt is never 1.
- On every grant, `last` is set to the winner.
- Lock transitions:
  - A grant with lock=1 moves the FSM to OWN_winner.
  - OWN_x returns to IDLE when x deasserts lock, or when x has no request for one full cycle.
- Starvation override:
  - When the blocked counter reaches STARVE_MAX, the next cycle grants the blocked requester one access regardless of lock.
  - The counter clears on that grant.
  - The FSM remains OWN_x afterwards.
- Counter width is 4 bits, saturating at STARVE_MAX. It clears on the blocked requester's grant, on that requester dropping req, or on reset.
- Read-return tag: a 2-stage shift records {valid, owner} per granted read. Writes produce no rvalid.
- res_addr and res_do hold their last values when idle. res_rd and res_wr default to 0.

## Timing
- Cycle t: req high and gnt asserted combinationally.
- Cycle t+1: registered res_rd/res_wr, res_addr, res_do present the access.
- Cycle t+2: for a read, x_rvalid = 1 and x_rdata = res_di. Total read latency is 2 cycles from grant.
- Back-to-back grants every cycle are supported. Read tags pipeline, so consecutive reads return in order, one per cycle.
- A write followed by a read of the same address on the next grant returns the new data. The RAM is write-first by order, and no bypass logic is needed.
- Reset values:
  - all outputs 0, res_addr 0
  - FSM IDLE, `last` = B, counters 0
  - tag pipeline cleared
- Reset asserted mid-read drops in-flight rvalids. No data is returned after reset releases.
- A requester must keep addr, we and wdata stable while req is high and gnt is low.

## Structure
- Shared package res_arb_pkg holds:
  - ADDR_W and DATA_W constants
  - state enum {IDLE, OWN_A, OWN_B}
  - requester id enum {REQ_A, REQ_B}
- No sub-module. The FSM, pointer, two counters and the 2-deep tag pipe are inline.

## Test plan
- Single read: A reads 0x0081, and RAM holds 0x05 → a_gnt at t, res_rd=1 with res_addr=0x0081 at t+1, a_rvalid=1 with a_rdata=0x05 at t+2, b_rvalid=0 throughout.
- Round-robin tie: A and B both request continuously (reads) → grants alternate A, B, A, B starting with A, and rdata returns in the same order.
- Lock: A issues a read then a write to 0x0100 with a_lock=1 while b_req is high → B is not granted until a_lock drops, unless the override fires.
- Starvation: A holds lock and requests every cycle, B requests → B is granted exactly on its 5th request cycle (STARVE_MAX=4 blocked cycles), then A resumes.
- Write/read ordering: B writes 0x3F to 0x3F7F, then reads 0x3F7F → b_rdata=0x3F two cycles after the read grant.
- Reset mid-read: assert reset in the cycle after a granted read → no rvalid afterwards; all outputs 0; the next tie goes to A.

Source files
------------

// File: rtl/res_arb_pkg.sv
// Shared types and constants for the result-RAM arbiter: bus widths, FSM states,
// requester ids, the read-return tag and the blocked-counter update rule.
package res_arb_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } arb_state_e;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e owner;
  } rd_tag_t;

  // Blocked counter: cleared by the requester's own grant or by it letting go of
  // req; otherwise counts (saturating) only while the other side owns the RAM.
  function automatic logic [CNT_W-1:0] starve_next(
    input logic [CNT_W-1:0] cnt,
    input logic             req,
    input logic             gnt,
    input logic             held_off,
    input logic [CNT_W-1:0] cnt_max
  );
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (gnt || !req) begin
      nxt = '0;
    end else if (held_off && (cnt < cnt_max)) begin
      nxt = cnt + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/res_ram_arbiter_if.sv
// One requester's port onto the result-RAM arbiter: request/command from the
// requester, combinational grant and the read-return path back to it.
interface res_ram_arbiter_if;
  import res_arb_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/res_ram_arbiter.sv
// Shares the single-port result RAM between the distance-transform engine (A) and
// the host port (B): round-robin, lockable ownership, starvation override, 2-cycle reads.
module res_ram_arbiter
  import res_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  res_ram_arbiter_if.slave  a_if,
  res_ram_arbiter_if.slave  b_if,
  output logic              res_rd_o,
  output logic              res_wr_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic [DATA_W-1:0] res_do_o,
  input  logic [DATA_W-1:0] res_di_i
);

  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  req_id_e           last_q, last_d;
  logic [CNT_W-1:0]  a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]  b_cnt_q, b_cnt_d;
  logic              a_gnt, b_gnt;
  logic              res_rd_q, res_rd_d;
  logic              res_wr_q, res_wr_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [DATA_W-1:0] res_do_q, res_do_d;
  rd_tag_t           tag1_q, tag1_d;
  rd_tag_t           tag2_q, tag2_d;
  logic              a_rvalid, b_rvalid;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values no matter how the always_ff blocks are ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner keeps the RAM while it both requests and holds lock.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (a_gnt && a_if.lock) begin
          state_d = OWN_A;
        end else if (b_gnt && b_if.lock) begin
          state_d = OWN_B;
        end
      end
      OWN_A:   if (!(a_if.req && a_if.lock)) state_d = IDLE;
      OWN_B:   if (!(b_if.req && b_if.lock)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_if.req && b_if.req) begin
          if (last_q == REQ_B) a_gnt = 1'b1;
          else                 b_gnt = 1'b1;
        end else if (a_if.req) begin
          a_gnt = 1'b1;
        end else if (b_if.req) begin
          b_gnt = 1'b1;
        end
      end
      OWN_A: begin
        if (b_if.req && (b_cnt_q == STARVE_CNT)) b_gnt = 1'b1;
        else if (a_if.req)                      a_gnt = 1'b1;
      end
      OWN_B: begin
        if (a_if.req && (a_cnt_q == STARVE_CNT)) a_gnt = 1'b1;
        else if (b_if.req)                      b_gnt = 1'b1;
      end
      default: begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
      end
    endcase
  end

  always_comb begin
    last_d     = last_q;
    res_rd_d   = 1'b0;
    res_wr_d   = 1'b0;
    res_addr_d = res_addr_q;
    res_do_d   = res_do_q;
    tag1_d     = '{valid: 1'b0, owner: REQ_A};
    if (a_gnt) begin
      last_d     = REQ_A;
      res_rd_d   = !a_if.we;
      res_wr_d   = a_if.we;
      res_addr_d = a_if.addr;
      res_do_d   = a_if.wdata;
      tag1_d     = '{valid: !a_if.we, owner: REQ_A};
    end else if (b_gnt) begin
      last_d     = REQ_B;
      res_rd_d   = !b_if.we;
      res_wr_d   = b_if.we;
      res_addr_d = b_if.addr;
      res_do_d   = b_if.wdata;
      tag1_d     = '{valid: !b_if.we, owner: REQ_B};
    end
    tag2_d  = tag1_q;
    a_cnt_d = starve_next(a_cnt_q, a_if.req, a_gnt, state_q == OWN_B, STARVE_CNT);
    b_cnt_d = starve_next(b_cnt_q, b_if.req, b_gnt, state_q == OWN_A, STARVE_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= REQ_B;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      res_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= '0;
      res_do_q   <= '0;
      tag1_q     <= '{valid: 1'b0, owner: REQ_A};
      tag2_q     <= '{valid: 1'b0, owner: REQ_A};
    end else begin
      last_q     <= last_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      res_rd_q   <= res_rd_d;
      res_wr_q   <= res_wr_d;
      res_addr_q <= res_addr_d;
      res_do_q   <= res_do_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
    end
  end

  // The RAM answers one cycle after res_rd, which is when the tag reaches stage 2.
  assign a_rvalid = tag2_q.valid && (tag2_q.owner == REQ_A);
  assign b_rvalid = tag2_q.valid && (tag2_q.owner == REQ_B);

  assign a_if.gnt    = a_gnt;
  assign b_if.gnt    = b_gnt;
  assign a_if.rvalid = a_rvalid;
  assign b_if.rvalid = b_rvalid;
  assign a_if.rdata  = a_rvalid ? res_di_i : '0;
  assign b_if.rdata  = b_rvalid ? res_di_i : '0;

  assign res_rd_o   = res_rd_q;
  assign res_wr_o   = res_wr_q;
  assign res_addr_o = res_addr_q;
  assign res_do_o   = res_do_q;

endmodule

// File: tb/tb_res_ram_arbiter.sv
// Bench for res_ram_arbiter: RAM model, shadow-memory scoreboard of read returns,
// and per-scenario tasks checking grant sequencing, locking, starvation and reset.
module tb_res_ram_arbiter;
  import res_arb_pkg::*;

  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  res_ram_arbiter_if a_if ();
  res_ram_arbiter_if b_if ();

  logic              res_rd, res_wr;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_do;
  logic [DATA_W-1:0] res_di;

  res_ram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_if       (a_if),
    .b_if       (b_if),
    .res_rd_o   (res_rd),
    .res_wr_o   (res_wr),
    .res_addr_o (res_addr),
    .res_do_o   (res_do),
    .res_di_i   (res_di)
  );

  typedef struct {
    req_id_e           owner;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] ram    [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];
  logic              ram_loaded = 1'b0;
  int                checks = 0;
  int                errors = 0;

  function automatic logic [DATA_W-1:0] init_val(int i);
    return (i == 'h81) ? 8'h05 : (8'(i) ^ 8'h5A);
  endfunction

  // Synchronous-read single-port RAM, loaded on the first clock edge.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else begin
      if (res_wr) ram[res_addr] <= res_do;
      if (res_rd) res_di <= ram[res_addr];
    end
  end

  // Monitor: one-hot grant, in-order read returns against the shadow memory.
  initial begin
    exp_t              e;
    req_id_e           got_owner;
    logic [DATA_W-1:0] got_data;
    logic [DATA_W-1:0] other_data;
    for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!reset) begin
        checks++;
        if (a_if.gnt === 1'b1 && b_if.gnt === 1'b1) begin
          errors++;
          $display("FAIL gnt_onehot: a_gnt=%b b_gnt=%b, required at most one high", a_if.gnt, b_if.gnt);
        end
        if (a_if.rvalid === 1'b1 || b_if.rvalid === 1'b1) begin
          checks++;
          got_owner  = (b_if.rvalid === 1'b1) ? REQ_B : REQ_A;
          got_data   = (b_if.rvalid === 1'b1) ? b_if.rdata : a_if.rdata;
          other_data = (b_if.rvalid === 1'b1) ? a_if.rdata : b_if.rdata;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid: a_rvalid=%b b_rvalid=%b with no read outstanding",
                     a_if.rvalid, b_if.rvalid);
          end else begin
            e = sb.pop_front();
            if ((a_if.rvalid === 1'b1 && b_if.rvalid === 1'b1) || got_owner != e.owner ||
                got_data !== e.data || other_data !== '0) begin
              errors++;
              $display("FAIL read_return: got owner=%s data=%h other=%h, required owner=%s data=%h other=00",
                       got_owner.name(), got_data, other_data, e.owner.name(), e.data);
            end
          end
        end
        if (a_if.gnt === 1'b1) begin
          if (a_if.we) shadow[a_if.addr] = a_if.wdata;
          else         sb.push_back('{owner: REQ_A, data: shadow[a_if.addr]});
        end else if (b_if.gnt === 1'b1) begin
          if (b_if.we) shadow[b_if.addr] = b_if.wdata;
          else         sb.push_back('{owner: REQ_B, data: shadow[b_if.addr]});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.lock = 1'b0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.lock = 1'b0; b_if.addr = '0; b_if.wdata = '0;
  endtask

  task automatic drive_a(logic req, logic we, logic lock, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wdata);
    a_if.req = req; a_if.we = we; a_if.lock = lock; a_if.addr = addr; a_if.wdata = wdata;
  endtask

  task automatic drive_b(logic req, logic we, logic lock, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wdata);
    b_if.req = req; b_if.we = we; b_if.lock = lock; b_if.addr = addr; b_if.wdata = wdata;
  endtask

  task automatic check_gnt(string name, logic exp_a, logic exp_b);
    checks++;
    if (a_if.gnt !== exp_a || b_if.gnt !== exp_b) begin
      errors++;
      $display("FAIL %s: a_gnt=%b b_gnt=%b, required a_gnt=%b b_gnt=%b", name, a_if.gnt, b_if.gnt, exp_a, exp_b);
    end
  endtask

  task automatic check_quiet(string name);
    checks++;
    if ({res_rd, res_wr, res_addr, res_do} !== '0 || a_if.gnt !== 1'b0 || b_if.gnt !== 1'b0 ||
        a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0 || a_if.rdata !== '0 || b_if.rdata !== '0) begin
      errors++;
      $display("FAIL %s: rd=%b wr=%b addr=%h do=%h gnt=%b%b rvalid=%b%b rdata=%h/%h, required all 0",
               name, res_rd, res_wr, res_addr, res_do, a_if.gnt, b_if.gnt,
               a_if.rvalid, b_if.rvalid, a_if.rdata, b_if.rdata);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads still outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    reset = 1'b1;
    sb.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    idle_inputs();
    reset = 1'b1;
    sb.delete();
    step();
    @(negedge clk);
    check_quiet("reset_outputs");
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    step();
    drive_a(1'b1, 1'b0, 1'b0, 14'h0081, 8'h00);
    @(negedge clk);
    check_gnt("single_gnt", 1'b1, 1'b0);
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (res_rd !== 1'b1 || res_wr !== 1'b0 || res_addr !== 14'h0081) begin
      errors++;
      $display("FAIL single_cmd: rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=0081", res_rd, res_wr, res_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (a_if.rvalid !== 1'b1 || a_if.rdata !== 8'h05 || b_if.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_data: a_rvalid=%b a_rdata=%h b_rvalid=%b, required 1 05 0",
               a_if.rvalid, a_if.rdata, b_if.rvalid);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int na = 0;
    int nb = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      drive_a(1'b1, 1'b0, 1'b0, 14'h0200 + 14'(na), 8'h00);
      drive_b(1'b1, 1'b0, 1'b0, 14'h0300 + 14'(nb), 8'h00);
      @(negedge clk);
      check_gnt($sformatf("rr_tie_%0d", k), 1'((k % 2) == 0), 1'((k % 2) == 1));
      if (a_if.gnt === 1'b1) na++;
      if (b_if.gnt === 1'b1) nb++;
    end
    step();
    idle_inputs();
    drain();
  endtask

  task automatic test_lock();
    logic exp_a [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_b [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      case (k)
        0:       drive_a(1'b1, 1'b0, 1'b1, 14'h0100, 8'h00);
        1:       drive_a(1'b1, 1'b1, 1'b1, 14'h0100, 8'hA7);
        default: drive_a(1'b0, 1'b0, 1'b0, 14'h0000, 8'h00);
      endcase
      drive_b(1'b1, 1'b0, 1'b0, 14'h0100, 8'h00);
      @(negedge clk);
      check_gnt($sformatf("lock_%0d", k), exp_a[k], exp_b[k]);
    end
    step();
    idle_inputs();
    drain();
  endtask

  task automatic test_starvation();
    logic b_done = 1'b0;
    int   na     = 0;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step();
      drive_a(1'b1, 1'b0, 1'b1, 14'h0600 + 14'(na), 8'h00);
      drive_b(1'((k >= 1) && !b_done), 1'b0, 1'b0, 14'h0500, 8'h00);
      @(negedge clk);
      check_gnt($sformatf("starve_%0d", k), 1'(k != 5), 1'(k == 5));
      if (a_if.gnt === 1'b1) na++;
      if (b_if.gnt === 1'b1) b_done = 1'b1;
    end
    step();
    idle_inputs();
    @(negedge clk);
    check_gnt("starve_release", 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_write_read();
    step();
    drive_b(1'b1, 1'b1, 1'b0, 14'h3F7F, 8'h3F);
    @(negedge clk);
    check_gnt("wr_gnt", 1'b0, 1'b1);
    step();
    drive_b(1'b1, 1'b0, 1'b0, 14'h3F7F, 8'h00);
    @(negedge clk);
    check_gnt("rd_gnt", 1'b0, 1'b1);
    step();
    idle_inputs();
    step();
    @(negedge clk);
    checks++;
    if (b_if.rvalid !== 1'b1 || b_if.rdata !== 8'h3F || a_if.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_then_read: b_rvalid=%b b_rdata=%h a_rvalid=%b, required 1 3F 0",
               b_if.rvalid, b_if.rdata, a_if.rvalid);
    end
    drain();
  endtask

  task automatic test_reset_mid_read();
    step();
    drive_a(1'b1, 1'b0, 1'b0, 14'h0042, 8'h00);
    @(negedge clk);
    check_gnt("midrd_gnt", 1'b1, 1'b0);
    step();
    idle_inputs();
    reset = 1'b1;
    sb.delete();
    step();
    @(negedge clk);
    check_quiet("midrd_reset_outputs");
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0) begin
        errors++;
        $display("FAIL midrd_no_rvalid: a_rvalid=%b b_rvalid=%b, required 0 0", a_if.rvalid, b_if.rvalid);
      end
      step();
    end
    drive_a(1'b1, 1'b0, 1'b0, 14'h0011, 8'h00);
    drive_b(1'b1, 1'b0, 1'b0, 14'h0022, 8'h00);
    @(negedge clk);
    check_gnt("midrd_tie_after_reset", 1'b1, 1'b0);
    step();
    idle_inputs();
    drain();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_starvation();
    test_write_read();
    test_reset_mid_read();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
